// File: rtl/ebpf_divmod_pkg.sv
// ============================================================================
// Module : ebpf_divmod_pkg
// Brief  : Shared widths, counter size and FSM state encoding for the
//          eBPF multi-cycle divide/modulus unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ebpf_divmod_pkg;

   localparam int DIVMOD_W64   = 64;
   localparam int DIVMOD_W32   = 32;
   localparam int REG_IDX_W    = 4;
   localparam int DIVMOD_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } divmod_state_e;

endpackage

`default_nettype wire

// File: rtl/ebpf_divmod_if.sv
// ============================================================================
// Module : ebpf_divmod_if
// Brief  : Operand and result valid/ready bundle of the divide/modulus unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ebpf_divmod_if;
   import ebpf_divmod_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [63:0]          in_a;
   logic [63:0]          in_b;
   logic                 in_is64;
   logic                 in_is_mod;
   logic [REG_IDX_W-1:0] in_dst;
   logic                 out_valid;
   logic                 out_ready;
   logic [63:0]          out_result;
   logic [REG_IDX_W-1:0] out_dst;
   logic                 busy;

   // master = operand-fetch/writeback side, slave = the execution unit
   modport master (
      output in_valid, in_a, in_b, in_is64, in_is_mod, in_dst, out_ready,
      input  in_ready, out_valid, out_result, out_dst, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_is64, in_is_mod, in_dst, out_ready,
      output in_ready, out_valid, out_result, out_dst, busy
   );

endinterface

`default_nettype wire

// File: rtl/divmod_step.sv
// ============================================================================
// Module : divmod_step
// Brief  : One combinational radix-2 restoring division iteration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module divmod_step #(
   parameter int W = 64
) (
   input  wire logic [W-1:0] rem,
   input  wire logic [W-1:0] divisor,
   input  wire logic         din,
   output logic      [W-1:0] rem_next,
   output logic              q
);

   logic [W:0] w_shift;
   logic [W:0] w_diff;
   logic       w_unused_diff_msb;

   // Shifted remainder is one bit wider so the compare never overflows
   assign w_shift           = {rem, din};
   assign w_diff            = w_shift - {1'b0, divisor};
   assign q                 = (w_shift >= {1'b0, divisor});
   assign rem_next          = q ? w_diff[W-1:0] : w_shift[W-1:0];
   assign w_unused_diff_msb = w_diff[W];

endmodule

`default_nettype wire

// File: rtl/ebpf_divmod_seq.sv
// ============================================================================
// Module : ebpf_divmod_seq
// Brief  : Multi-cycle unsigned BPF_DIV / BPF_MOD unit, one quotient bit per
//          cycle. Define EBPF_DIVMOD_ALU64_EN to build the 64-bit datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ebpf_divmod_seq
   import ebpf_divmod_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         rst,
   ebpf_divmod_if.slave      bus
);

`ifdef EBPF_DIVMOD_ALU64_EN
   localparam int DP_W = DIVMOD_W64;
`else
   localparam int DP_W = DIVMOD_W32;
`endif

   localparam logic [DIVMOD_CNT_W-1:0] c_cnt_last32 = DIVMOD_CNT_W'(DIVMOD_W32 - 1);

   divmod_state_e         r_state, w_state_nxt;
   logic [DP_W-1:0]       r_rem, w_rem_nxt;
   logic [DP_W-1:0]       r_quo, w_quo_nxt;
   logic [DP_W-1:0]       r_div, w_div_nxt;
   logic [DIVMOD_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic                  r_is_mod, w_is_mod_nxt;
   logic [REG_IDX_W-1:0]  r_dst, w_dst_nxt;

   logic [DP_W-1:0]       w_a_eff;
   logic [DP_W-1:0]       w_b_eff;
   logic [DP_W-1:0]       w_a_load;
   logic [DIVMOD_CNT_W-1:0] w_cnt_init;
   logic [DP_W-1:0]       w_step_rem;
   logic                  w_step_q;

`ifdef EBPF_DIVMOD_ALU64_EN
   localparam logic [DIVMOD_CNT_W-1:0] c_cnt_last64 = DIVMOD_CNT_W'(DIVMOD_W64 - 1);
   logic w_is64;

   assign w_is64     = bus.in_is64;
   assign w_a_eff    = w_is64 ? bus.in_a : {{DIVMOD_W32{1'b0}}, bus.in_a[31:0]};
   assign w_b_eff    = w_is64 ? bus.in_b : {{DIVMOD_W32{1'b0}}, bus.in_b[31:0]};
   // ALU32 dividend is left-aligned so its MSB is always r_quo[DP_W-1]
   // and the zeros behind it end up as the upper quotient bits.
   assign w_a_load   = w_is64 ? bus.in_a : {bus.in_a[31:0], {DIVMOD_W32{1'b0}}};
   assign w_cnt_init = w_is64 ? c_cnt_last64 : c_cnt_last32;
   assign bus.out_result = r_is_mod ? r_rem : r_quo;
`else
   logic w_unused_hi;

   assign w_a_eff    = bus.in_a[31:0];
   assign w_b_eff    = bus.in_b[31:0];
   assign w_a_load   = bus.in_a[31:0];
   assign w_cnt_init = c_cnt_last32;
   assign bus.out_result = {{DIVMOD_W32{1'b0}}, (r_is_mod ? r_rem : r_quo)};
   assign w_unused_hi = ^{bus.in_a[63:32], bus.in_b[63:32], bus.in_is64};
`endif

   divmod_step #(.W(DP_W)) u_step (
      .rem      (r_rem),
      .divisor  (r_div),
      .din      (r_quo[DP_W-1]),
      .rem_next (w_step_rem),
      .q        (w_step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_is_mod <= 1'b0;
         r_dst    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
         r_div    <= w_div_nxt;
         r_cnt    <= w_cnt_nxt;
         r_is_mod <= w_is_mod_nxt;
         r_dst    <= w_dst_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      w_quo_nxt    = r_quo;
      w_div_nxt    = r_div;
      w_cnt_nxt    = r_cnt;
      w_is_mod_nxt = r_is_mod;
      w_dst_nxt    = r_dst;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_is_mod_nxt = bus.in_is_mod;
               w_dst_nxt    = bus.in_dst;
               w_div_nxt    = w_b_eff;
               // Zero divisor: quotient 0, remainder = dividend
               if (w_b_eff == '0) begin
                  w_rem_nxt   = w_a_eff;
                  w_quo_nxt   = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_rem_nxt   = '0;
                  w_quo_nxt   = w_a_load;
                  w_cnt_nxt   = w_cnt_init;
                  w_state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            w_rem_nxt = w_step_rem;
            w_quo_nxt = {r_quo[DP_W-2:0], w_step_q};
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_dst   = r_dst;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
